// File: rtl/tqvp_stevej_wdt_pkg.sv
// Shared types and constants for the watchdog escalator: FSM state encoding,
// register map and CTRL bit positions.
package tqvp_stevej_wdt_pkg;

  // Encoding is visible on the debug PMOD, so values are fixed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN  = 2'd1,
    RESET = 2'd2,
    HOLD  = 2'd3
  } esc_state_t;

  localparam logic [5:0] ADDR_CTRL      = 6'h0;
  localparam logic [5:0] ADDR_GRACE     = 6'h1;
  localparam logic [5:0] ADDR_RST_WIDTH = 6'h2;
  localparam logic [5:0] ADDR_ACK       = 6'h3;
  localparam logic [5:0] ADDR_EXP_COUNT = 6'h4;

  localparam int EN_BIT   = 0;
  localparam int LOCK_BIT = 1;

endpackage

// File: rtl/tqvp_stevej_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so a long run of events never reads back as a small number.
module tqvp_stevej_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // Clear has priority over increment; increment stops at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tqvp_stevej_wdt_escalator.sv
// Watchdog escalator: turns a watchdog expiry into a warning interrupt and,
// if firmware does not acknowledge within GRACE cycles, a fixed-width
// active-low reset pulse. Register file, edge detect and FSM live here.
module tqvp_stevej_wdt_escalator
  import tqvp_stevej_wdt_pkg::*;
#(
  parameter int GRACE_W = 16,
  parameter int RST_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wdt_expired,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        esc_irq,
  output logic        esc_reset_n,
  output logic [1:0]  esc_state
);

  esc_state_t         state, state_d;
  logic [GRACE_W-1:0] grace, grace_cnt, grace_cnt_d;
  logic [RST_W-1:0]   rst_width, rst_cnt, rst_cnt_d, rst_last;
  logic [CNT_W-1:0]   exp_count;
  logic               en, lock, wdt_expired_q;
  logic               wr, ctrl_wr, grace_wr, rst_width_wr, ack, exp_clr;
  logic               en_eff, rise, warn_entry;

  // Reads have no side effects and only the low write bits are meaningful.
  logic unused_bits;
  assign unused_bits = &{1'b0, data_read_n, data_in[31:GRACE_W]};

  // Bus decode; configuration writes are dropped once LOCK is set, but the
  // counter clear and ACK stay available to firmware.
  assign wr           = (data_write_n != 2'b11);
  assign ctrl_wr      = wr && (address == ADDR_CTRL) && !lock;
  assign grace_wr     = wr && (address == ADDR_GRACE) && !lock;
  assign rst_width_wr = wr && (address == ADDR_RST_WIDTH) && !lock;
  assign ack          = wr && (address == ADDR_ACK) && data_in[0];
  assign exp_clr      = wr && (address == ADDR_EXP_COUNT);

  // A disabling CTRL write acts on the FSM in the same cycle it is issued.
  assign en_eff = ctrl_wr ? data_in[EN_BIT] : en;
  assign rise   = wdt_expired && !wdt_expired_q;

  // A width of 0 behaves as 1, so the last count index is clamped at 0.
  assign rst_last = (rst_width == '0) ? '0 : rst_width - RST_W'(1);

  // Configuration registers and the expiry edge-detect flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en            <= 1'b0;
      lock          <= 1'b0;
      grace         <= '0;
      rst_width     <= '0;
      wdt_expired_q <= 1'b0;
    end else begin
      wdt_expired_q <= wdt_expired;
      if (ctrl_wr) begin
        en   <= data_in[EN_BIT];
        lock <= data_in[LOCK_BIT];
      end
      if (grace_wr)     grace     <= data_in[GRACE_W-1:0];
      if (rst_width_wr) rst_width <= data_in[RST_W-1:0];
    end
  end

  // FSM state and its two cycle counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      grace_cnt <= '0;
      rst_cnt   <= '0;
    end else begin
      state     <= state_d;
      grace_cnt <= grace_cnt_d;
      rst_cnt   <= rst_cnt_d;
    end
  end

  // Next-state logic; counters compare with >= so a live shrink of GRACE or
  // RST_WIDTH below the running count still terminates instead of wrapping.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path can
    // leave a signal unassigned and infer a latch.
    state_d     = state;
    grace_cnt_d = grace_cnt;
    rst_cnt_d   = rst_cnt;
    warn_entry  = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_eff && rise) begin
          state_d     = WARN;
          grace_cnt_d = '0;
          warn_entry  = 1'b1;
        end
      end
      WARN: begin
        if (!en_eff) begin
          state_d = IDLE;
        end else if (grace_cnt >= grace) begin
          state_d   = RESET;
          rst_cnt_d = '0;
        end else if (ack) begin
          state_d = IDLE;
        end else begin
          grace_cnt_d = grace_cnt + GRACE_W'(1);
        end
      end
      RESET: begin
        if (rst_cnt >= rst_last) begin
          state_d = HOLD;
        end else begin
          rst_cnt_d = rst_cnt + RST_W'(1);
        end
      end
      HOLD: begin
        if (!en_eff || !wdt_expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  tqvp_stevej_sat_counter #(
    .WIDTH (CNT_W)
  ) u_exp_count (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (warn_entry),
    .clr   (exp_clr),
    .count (exp_count)
  );

  // Combinational register readback.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:      data_out = {30'b0, lock, en};
      ADDR_GRACE:     data_out = 32'(grace);
      ADDR_RST_WIDTH: data_out = 32'(rst_width);
      ADDR_ACK:       data_out = {28'b0, lock, en, state};
      ADDR_EXP_COUNT: data_out = 32'(exp_count);
      default:        data_out = '0;
    endcase
  end

  assign data_ready  = 1'b1;
  assign esc_irq     = (state == WARN);
  assign esc_reset_n = (state != RESET);
  assign esc_state   = state;

endmodule

// File: tb/tb_tqvp_stevej_wdt_escalator.sv
// Directed testbench for the watchdog escalator. Inputs change 1 ns after the
// rising edge; outputs are sampled there too, well clear of the next edge.
module tb_tqvp_stevej_wdt_escalator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wdt_expired;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        esc_irq;
  logic        esc_reset_n;
  logic [1:0]  esc_state;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] A_CTRL  = 6'h0;
  localparam logic [5:0] A_GRACE = 6'h1;
  localparam logic [5:0] A_RSTW  = 6'h2;
  localparam logic [5:0] A_ACK   = 6'h3;
  localparam logic [5:0] A_EXP   = 6'h4;

  tqvp_stevej_wdt_escalator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wdt_expired  (wdt_expired),
    .address      (address),
    .data_in      (data_in),
    .data_write_n (data_write_n),
    .data_read_n  (data_read_n),
    .data_out     (data_out),
    .data_ready   (data_ready),
    .esc_irq      (esc_irq),
    .esc_reset_n  (esc_reset_n),
    .esc_state    (esc_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    tick();
    data_write_n = 2'b11;
    data_in      = '0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0;
    wdt_expired = 1'b0;
    tick();
    tick();
    checks++; if (esc_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", esc_irq); end
    checks++; if (esc_reset_n !== 1'b1) begin errors++; $display("FAIL reset_rstn got %b exp 1", esc_reset_n); end
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", esc_state); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", data_ready); end
    for (int a = 0; a < 6; a++) begin
      bus_read(6'(a), rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_reg%0d got %h exp 0", a, rd); end
    end
    rst_n = 1'b1;
    tick();
  endtask

  // GRACE=5, RST_WIDTH=3: irq in T+1..T+6, reset low in T+7..T+9, then HOLD.
  task automatic test_escalation();
    logic [31:0] rd;
    bus_write(A_CTRL, 32'h1);
    bus_write(A_GRACE, 32'd5);
    bus_write(A_RSTW, 32'd3);
    wdt_expired = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      checks++; if (esc_irq !== (k <= 6)) begin errors++; $display("FAIL esc_irq_T+%0d got %b exp %b", k, esc_irq, (k <= 6)); end
      checks++; if (esc_reset_n !== !(k >= 7 && k <= 9)) begin errors++; $display("FAIL esc_rstn_T+%0d got %b exp %b", k, esc_reset_n, !(k >= 7 && k <= 9)); end
      tick();
    end
    checks++; if (esc_state !== 2'd3) begin errors++; $display("FAIL esc_hold got %0d exp 3", esc_state); end
    wdt_expired = 1'b0;
    tick();
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL esc_idle got %0d exp 0", esc_state); end
    bus_read(A_EXP, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL esc_expcount got %0d exp 1", rd); end
  endtask

  task automatic test_ack();
    logic [31:0] rd;
    wdt_expired = 1'b1;
    tick();
    checks++; if (esc_irq !== 1'b1) begin errors++; $display("FAIL ack_warn got %b exp 1", esc_irq); end
    wdt_expired = 1'b0;
    tick();
    tick();
    bus_write(A_ACK, 32'h1);
    checks++; if (esc_irq !== 1'b0) begin errors++; $display("FAIL ack_irq got %b exp 0", esc_irq); end
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL ack_state got %0d exp 0", esc_state); end
    for (int i = 0; i < 10; i++) begin
      checks++; if (esc_reset_n !== 1'b1) begin errors++; $display("FAIL ack_norst_%0d got %b exp 1", i, esc_reset_n); end
      tick();
    end
    bus_read(A_EXP, rd);
    checks++; if (rd !== 32'd2) begin errors++; $display("FAIL ack_expcount got %0d exp 2", rd); end
  endtask

  // ACK lands in T+6 when grace_cnt==GRACE; reset must still happen at full width.
  task automatic test_ack_race();
    int low_cycles;
    wdt_expired = 1'b1;
    tick();
    repeat (5) tick();
    bus_write(A_ACK, 32'h1);
    checks++; if (esc_state !== 2'd2) begin errors++; $display("FAIL race_state got %0d exp 2", esc_state); end
    checks++; if (esc_irq !== 1'b0) begin errors++; $display("FAIL race_irq got %b exp 0", esc_irq); end
    low_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (esc_reset_n === 1'b0) low_cycles++;
      tick();
    end
    checks++; if (low_cycles !== 3) begin errors++; $display("FAIL race_width got %0d exp 3", low_cycles); end
    checks++; if (esc_state !== 2'd3) begin errors++; $display("FAIL race_hold got %0d exp 3", esc_state); end
    wdt_expired = 1'b0;
    tick();
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL race_idle got %0d exp 0", esc_state); end
  endtask

  task automatic test_disable();
    wdt_expired = 1'b1;
    tick();
    checks++; if (esc_state !== 2'd1) begin errors++; $display("FAIL dis_warn got %0d exp 1", esc_state); end
    wdt_expired = 1'b0;
    bus_write(A_CTRL, 32'h0);
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL dis_state got %0d exp 0", esc_state); end
    checks++; if (esc_irq !== 1'b0) begin errors++; $display("FAIL dis_irq got %b exp 0", esc_irq); end
    bus_write(A_CTRL, 32'h1);
  endtask

  task automatic test_lock();
    logic [31:0] rd;
    bus_write(A_CTRL, 32'h3);
    bus_write(A_CTRL, 32'h0);
    bus_write(A_GRACE, 32'hFFFF);
    bus_read(A_ACK, rd);
    checks++; if (rd !== 32'hC) begin errors++; $display("FAIL lock_status got %h exp c", rd); end
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL lock_ctrl got %h exp 3", rd); end
    bus_read(A_GRACE, rd);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL lock_grace got %h exp 5", rd); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL lock_cleared got %h exp 0", rd); end
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL lock_rewrite got %h exp 1", rd); end
  endtask

  // GRACE=0, RST_WIDTH=0: reset low only in T+2; held expiry stays in HOLD.
  task automatic test_zero_grace();
    logic [31:0] rd;
    bus_write(A_GRACE, 32'd0);
    bus_write(A_RSTW, 32'd0);
    wdt_expired = 1'b1;
    tick();
    checks++; if (esc_irq !== 1'b1) begin errors++; $display("FAIL zero_warn got %b exp 1", esc_irq); end
    tick();
    checks++; if (esc_reset_n !== 1'b0) begin errors++; $display("FAIL zero_rstlow got %b exp 0", esc_reset_n); end
    tick();
    checks++; if (esc_reset_n !== 1'b1) begin errors++; $display("FAIL zero_rstend got %b exp 1", esc_reset_n); end
    checks++; if (esc_state !== 2'd3) begin errors++; $display("FAIL zero_hold got %0d exp 3", esc_state); end
    repeat (5) tick();
    checks++; if (esc_state !== 2'd3) begin errors++; $display("FAIL zero_noretrig got %0d exp 3", esc_state); end
    checks++; if (esc_irq !== 1'b0) begin errors++; $display("FAIL zero_noirq got %b exp 0", esc_irq); end
    bus_read(A_EXP, rd);
    checks++; if (rd !== 32'd1) begin errors++; $display("FAIL zero_expcount got %0d exp 1", rd); end
    wdt_expired = 1'b0;
    tick();
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL zero_idle got %0d exp 0", esc_state); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd;
    bus_write(A_GRACE, 32'd100);
    for (int i = 0; i < 300; i++) begin
      wdt_expired = 1'b1;
      tick();
      wdt_expired = 1'b0;
      bus_write(A_ACK, 32'h1);
    end
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL sat_state got %0d exp 0", esc_state); end
    bus_read(A_EXP, rd);
    checks++; if (rd !== 32'hFF) begin errors++; $display("FAIL sat_count got %h exp ff", rd); end
    bus_write(A_EXP, 32'h0);
    bus_read(A_EXP, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sat_clear got %h exp 0", rd); end
  endtask

  task automatic test_reset_mid_pulse();
    bus_write(A_GRACE, 32'd0);
    bus_write(A_RSTW, 32'd10);
    wdt_expired = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (esc_reset_n !== 1'b0) begin errors++; $display("FAIL mid_pulse got %b exp 0", esc_reset_n); end
    rst_n = 1'b0;
    tick();
    checks++; if (esc_reset_n !== 1'b1) begin errors++; $display("FAIL mid_rstn got %b exp 1", esc_reset_n); end
    checks++; if (esc_state !== 2'd0) begin errors++; $display("FAIL mid_state got %0d exp 0", esc_state); end
    rst_n = 1'b1;
    wdt_expired = 1'b0;
    tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    wdt_expired  = 1'b0;
    address      = '0;
    data_in      = '0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    test_reset();
    test_escalation();
    test_ack();
    test_ack_race();
    test_disable();
    test_lock();
    test_zero_grace();
    test_saturation();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout got running exp finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_stevej_wdt_escalator.md
Name: tqvp_stevej_wdt_escalator

Overview:
- Downstream consumer of the watchdog's `timer_expired` / `user_interrupt` line.
- Converts an expiry into a two-stage escalation:
  - first a warning interrupt that the CPU may acknowledge;
  - if not acknowledged within a programmable grace period, a fixed-width active-low system reset pulse.
- Sits on the TinyQV peripheral bus beside the watchdog.
- Keeps a saturating expiry count and a lock bit so firmware cannot silently disarm escalation.

Parameters:
- GRACE_W, 16, width of the grace-period register and counter (cycles).
- RST_W, 8, width of the reset-pulse-width register and counter.
- CNT_W, 8, width of the saturating expiry counter.

Ports:
- clk  input  1  project clock (64 MHz nominal).
- rst_n  input  1  reset, synchronous, active-low.
- wdt_expired  input  1  level from the watchdog; high while its timer is expired.
- address  input  6  register address within this peripheral.
- data_in  input  32  write data; low bits valid per size.
- data_write_n  input  2  11 = no write, else write.
- data_read_n  input  2  unused; reads are side-effect free.
- data_out  output  32  read data, combinational on address.
- data_ready  output  1  constant 1.
- esc_irq  output  1  warning interrupt, high in WARN.
- esc_reset_n  output  1  system reset request, low in RESET.
- esc_state  output  2  current FSM state, for the debug PMOD.

Behaviour:
- One clock; all state updates on posedge clk.
- Reset is synchronous and active-low. Reset values:
  - state IDLE, esc_irq=0, esc_reset_n=1, esc_state=0;
  - all registers 0;
  - wdt_expired edge register cleared to 0.
- Registers (word addresses):
  - 0x0 CTRL: bit0 EN, bit1 LOCK.
    - LOCK is sticky; it can only be set, and is cleared only by rst_n.
    - While LOCK=1, writes to CTRL, GRACE and RST_WIDTH are ignored.
    - A write that sets LOCK also applies the EN bit carried in the same write.
  - 0x1 GRACE: GRACE_W bits, cycles from WARN entry to RESET.
  - 0x2 RST_WIDTH: RST_W bits, reset pulse length in cycles; value 0 is treated as 1.
  - 0x3 ACK:
    - write with data_in[0]=1 acknowledges the warning;
    - read returns {28'b0, LOCK, EN, esc_state}.
  - 0x4 EXP_COUNT:
    - read-only; incremented on each WARN entry, saturating at all-ones;
    - any write clears it, regardless of LOCK.
  - Other addresses read as 0; writes to them are ignored.
- Edge detect: rise = wdt_expired & ~wdt_expired_q, where wdt_expired_q is a 1-cycle register.
- FSM (esc_state encoding): IDLE=0, WARN=1, RESET=2, HOLD=3.
  - IDLE:
    - EN & rise → WARN, next cycle;
    - on entry: grace_cnt=0, EXP_COUNT++.
  - WARN (esc_irq=1):
    - if grace_cnt == GRACE → RESET, with rst_cnt=0;
    - else if ACK → IDLE;
    - else grace_cnt++;
    - GRACE=0 means RESET on the cycle after WARN entry.
    - Latency from rise to esc_reset_n low = GRACE+2 cycles.
  - RESET (esc_reset_n=0, esc_irq=0):
    - rst_cnt++;
    - when rst_cnt == max(RST_WIDTH,1)-1 → HOLD;
    - the pulse is exactly max(RST_WIDTH,1) cycles.
  - HOLD:
    - wait until wdt_expired==0, then → IDLE.
    - This prevents re-arm on a still-expired watchdog.
- Priorities and simultaneous events:
  - In WARN, grace expiry beats ACK in the same cycle: reset proceeds.
  - EN=0, whether written or already 0, forces IDLE from WARN or HOLD next cycle and clears esc_irq.
  - RESET is never aborted by EN=0 or by ACK; the pulse always completes.
  - ACK outside WARN has no effect.
  - rise while in WARN, RESET or HOLD is ignored and is not counted.
  - rst_n low mid-pulse returns esc_reset_n to 1 immediately on that edge.
- GRACE and RST_WIDTH are sampled live. Changing them mid-WARN or mid-RESET (only possible while unlocked) takes effect in the next comparison.
- Counters never wrap.
  - grace_cnt stops at GRACE.
  - EXP_COUNT saturates.

Decomposition:
- Package tqvp_stevej_wdt_pkg holds:
  - the esc_state_t enum (IDLE/WARN/RESET/HOLD);
  - the register address constants ADDR_CTRL/GRACE/RST_WIDTH/ACK/EXP_COUNT;
  - the CTRL bit indices EN_BIT and LOCK_BIT.
- Optional sub-module tqvp_stevej_sat_counter (parameterised width, inc/clr, saturate), reused for EXP_COUNT.
- The FSM, register file and edge detect stay in the top module.

Test Plan:
- EN=1, GRACE=5, RST_WIDTH=3; pulse wdt_expired high at cycle T → esc_irq=1 at T+1; esc_reset_n low for cycles T+7..T+9 exactly; HOLD until wdt_expired drops, then IDLE; EXP_COUNT=1.
- Same setup, write ACK=1 at T+3 → esc_irq=0 at T+4, esc_reset_n never low, state IDLE.
- Write ACK in the same cycle grace_cnt==GRACE → RESET entered anyway; pulse full width.
- Write CTRL=0b11 (EN+LOCK), then CTRL=0 and GRACE=0xFFFF → reads return CTRL EN=1 LOCK=1, GRACE unchanged; only rst_n clears LOCK.
- GRACE=0, RST_WIDTH=0 → reset pulse exactly 1 cycle, starting 2 cycles after rise; an expiry held high through HOLD does not re-trigger WARN.
- Drive 300 expiry rise/fall cycles with ACK each time → EXP_COUNT reads 0xFF (saturated); a write to 0x4 clears it to 0; assert rst_n mid-RESET → esc_reset_n=1 and state IDLE the next cycle.
